// File: rtl/pid_seq_pkg.sv
// Shared types and constants for the PID sample-cycle sequencer.
package pid_seq_pkg;
    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CAPTURE,
        SEQ_COMPUTE,
        SEQ_SETTLE,
        SEQ_EMIT
    } seq_state_t;

    localparam int SEQ_TIMEOUT_DEFAULT = 255;
    localparam int OVR_CNT_W           = 8;
    localparam int WAIT_CNT_W          = 8;
endpackage

// File: rtl/pid_seq_timer.sv
// Sample-period up-counter; raises tick once per period, held at zero while
// paused or when the period is zero.
module pid_seq_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);
    logic [PERIOD_W-1:0] cnt_reg;
    logic [PERIOD_W-1:0] cnt_next;
    logic [PERIOD_W-1:0] period_last;
    logic                period_zero;

    assign period_zero = (period == '0);
    assign period_last = period - PERIOD_W'(1);
    // >= rather than == so a shrinking period fires at once instead of wrapping
    assign tick = !hold && !period_zero && (cnt_reg >= period_last);

    always_comb begin
        cnt_next = cnt_reg + PERIOD_W'(1);
        if (hold || period_zero || tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: rtl/pid_sample_sequencer.sv
// Control-cycle sequencer: PV capture, PID strobe, stimulus emit, with
// transfer timeouts, overrun tracking and between-cycle config gating.
module pid_sample_sequencer
    import pid_seq_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = SEQ_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic [PERIOD_W-1:0]  period,
    input  logic                 in_done,
    input  logic                 out_done,
    input  logic                 cfg_req,
    output logic                 in_start,
    output logic                 pid_stb,
    output logic                 out_start,
    output logic                 cfg_apply,
    output logic                 busy,
    output logic                 overrun,
    output logic                 fault,
    output logic [OVR_CNT_W-1:0] overrun_cnt
);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    seq_state_t            state_reg, state_next;
    logic [WAIT_CNT_W-1:0] wait_reg, wait_next;
    logic                  in_start_reg, in_start_next;
    logic                  pid_stb_reg, pid_stb_next;
    logic                  out_start_reg, out_start_next;
    logic                  cfg_apply_reg, cfg_apply_next;
    logic                  busy_reg, busy_next;
    logic                  overrun_reg, overrun_next;
    logic                  fault_reg, fault_next;
    logic [OVR_CNT_W-1:0]  ovr_cnt_reg, ovr_cnt_next;
    logic                  pending_reg, pending_next;
    logic                  tick;

    pid_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .hold   (hold),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_next     = state_reg;
        wait_next      = wait_reg;
        in_start_next  = 1'b0;
        pid_stb_next   = 1'b0;
        out_start_next = 1'b0;
        fault_next     = fault_reg;
        overrun_next   = overrun_reg;
        ovr_cnt_next   = ovr_cnt_reg;

        // config lands only in an idle cycle the tick does not claim
        cfg_apply_next = (state_reg == SEQ_IDLE) && !tick && pending_reg;
        pending_next   = cfg_req || (pending_reg && !cfg_apply_next);

        if (tick && (state_reg != SEQ_IDLE)) begin
            overrun_next = 1'b1;
            if (ovr_cnt_reg != '1) begin
                ovr_cnt_next = ovr_cnt_reg + OVR_CNT_W'(1);
            end
        end

        if (hold) begin
            state_next = SEQ_IDLE;
        end else begin
            case (state_reg)
                SEQ_IDLE: begin
                    if (tick) begin
                        state_next    = SEQ_CAPTURE;
                        wait_next     = '0;
                        in_start_next = 1'b1;
                    end
                end
                SEQ_CAPTURE: begin
                    if (in_done) begin
                        state_next   = SEQ_COMPUTE;
                        pid_stb_next = 1'b1;
                    end else if (wait_reg == WAIT_LAST) begin
                        state_next = SEQ_IDLE;
                        fault_next = 1'b1;
                    end else begin
                        wait_next = wait_reg + WAIT_CNT_W'(1);
                    end
                end
                SEQ_COMPUTE: state_next = SEQ_SETTLE;
                SEQ_SETTLE: begin
                    state_next     = SEQ_EMIT;
                    wait_next      = '0;
                    out_start_next = 1'b1;
                end
                SEQ_EMIT: begin
                    if (out_done) begin
                        state_next = SEQ_IDLE;
                    end else if (wait_reg == WAIT_LAST) begin
                        state_next = SEQ_IDLE;
                        fault_next = 1'b1;
                    end else begin
                        wait_next = wait_reg + WAIT_CNT_W'(1);
                    end
                end
                default: state_next = SEQ_IDLE;
            endcase
        end

        busy_next = (state_next != SEQ_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= SEQ_IDLE;
            wait_reg      <= '0;
            in_start_reg  <= 1'b0;
            pid_stb_reg   <= 1'b0;
            out_start_reg <= 1'b0;
            cfg_apply_reg <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            fault_reg     <= 1'b0;
            ovr_cnt_reg   <= '0;
            pending_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            in_start_reg  <= in_start_next;
            pid_stb_reg   <= pid_stb_next;
            out_start_reg <= out_start_next;
            cfg_apply_reg <= cfg_apply_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
            fault_reg     <= fault_next;
            ovr_cnt_reg   <= ovr_cnt_next;
            pending_reg   <= pending_next;
        end
    end

    assign in_start    = in_start_reg;
    assign pid_stb     = pid_stb_reg;
    assign out_start   = out_start_reg;
    assign cfg_apply   = cfg_apply_reg;
    assign busy        = busy_reg;
    assign overrun     = overrun_reg;
    assign fault       = fault_reg;
    assign overrun_cnt = ovr_cnt_reg;
endmodule
